// File: rtl/hermes_input_buffer.sv
// Purpose: per-port input FIFO plus packet-framing FSM for one router port.
//          Requests routing while a header sits at the head and streams the granted packet.
// Latency: first write to h is two cycles; ack_h to data_av/sender is one cycle; data_out is combinational from the head.
// Backpressure: credit_o drops when full, data_av is held off until the grant, and pops happen only on data_av && data_ack.
//
// Ports: clock/reset (sync, active-low); rx/data_in/credit_o link side;
//        h/ack_h routing handshake; data_out/data_av/data_ack crossbar side;
//        sender marks a granted packet in flight.
// Optional build macro HERMES_IBUF_STATUS_EN adds occupancy (FIFO count) and
// pkt_err (sticky overflow-attempt flag, cleared only by reset).
module hermes_input_buffer #(
    parameter int DEPTH  = 16,
    parameter int FLIT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    input  logic [FLIT_W-1:0] data_in,
    output logic              credit_o,
    output logic              h,
    input  logic              ack_h,
    output logic [FLIT_W-1:0] data_out,
    output logic              data_av,
    input  logic              data_ack,
    output logic              sender
`ifdef HERMES_IBUF_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   pkt_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [FLIT_W-1:0] FLIT_ONE = FLIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_HDR, S_SIZE, S_PAYLOAD, S_END
    } state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    state_t            state_q;
    logic              h_q, sender_q;
    logic [FLIT_W-1:0] flit_cnt_q;

    logic empty, full, push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign credit_o = !full;
    assign push     = rx && !full;
    assign data_out = mem[rd_ptr_q];
    // Only the streaming states forward flits; REQ shows the header without offering it.
    assign data_av  = !empty && (state_q == S_HDR || state_q == S_SIZE || state_q == S_PAYLOAD);
    assign pop      = data_av && data_ack;
    assign h        = h_q;
    assign sender   = sender_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        // Simultaneous push and pop leaves the count unchanged.
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    // Storage has no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            h_q        <= 1'b0;
            sender_q   <= 1'b0;
            flit_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_q <= S_REQ;
                        h_q     <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ack_h) begin
                        h_q      <= 1'b0;
                        sender_q <= 1'b1;
                        state_q  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (pop) state_q <= S_SIZE;
                end
                S_SIZE: begin
                    if (pop) begin
                        flit_cnt_q <= data_out;
                        state_q    <= (data_out == '0) ? S_END : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // flit_cnt is at least 1 here, so the decrement never wraps.
                    if (pop) begin
                        flit_cnt_q <= flit_cnt_q - FLIT_ONE;
                        if (flit_cnt_q == FLIT_ONE) state_q <= S_END;
                    end
                end
                S_END: begin
                    // sender stays high through END so the switch sees a clean falling edge.
                    sender_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef HERMES_IBUF_STATUS_EN
    logic pkt_err_q;

    assign occupancy = count_q;
    assign pkt_err   = pkt_err_q;

    always_ff @(posedge clock) begin
        if (!reset)                pkt_err_q <= 1'b0;
        else if (rx && !credit_o)  pkt_err_q <= 1'b1;
    end
`endif

endmodule

// File: doc/hermes_input_buffer.md
# hermes_input_buffer

Per-port input FIFO and packet-framing FSM for one router port. It sits directly upstream of the router's switch control / crossbar: it stores incoming flits from the link, raises a routing request `h` while a header is at the head, and streams the packet once the request is acknowledged. `sender` is held high for the whole packet so the switch control can free the output on its falling edge. Packet format: flit 0 = header (target X in [15:12], Y in [11:8]), flit 1 = payload size N, then N payload flits.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `FLIT_W`, 16: flit width in bits.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx`  in  1  link-side write strobe.
- `data_in`  in  FLIT_W  link-side flit.
- `credit_o`  out  1  space available; a flit is written when `rx && credit_o`.
- `h`  out  1  routing request to switch control.
- `ack_h`  in  1  routing grant from switch control.
- `data_out`  out  FLIT_W  flit at FIFO head, combinational from the buffer.
- `data_av`  out  1  `data_out` is valid for forwarding.
- `data_ack`  in  1  downstream consumed `data_out`; pop occurs when `data_av && data_ack`.
- `sender`  out  1  high while a granted packet is in flight.

## Operation
- FIFO: `rd_ptr`/`wr_ptr` of log2(DEPTH) bits wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits. `empty = count==0`, `full = count==DEPTH`. `credit_o = !full`.
- Simultaneous push and pop: both pointers advance and `count` is unchanged. A push while full cannot occur. A pop while empty cannot occur because `data_av` is gated by `!empty`.
- FSM states: IDLE, REQ, HDR, SIZE, PAYLOAD, END.
  - IDLE: when `!empty`, go to REQ.
  - REQ: `h=1`, and the header is presented on `data_out`. On `ack_h=1`, clear `h`, set `sender=1`, and go to HDR. No pop happens in REQ.
  - HDR: `data_av=!empty`. On pop, go to SIZE.
  - SIZE: `data_av=!empty`. On pop, load `flit_cnt <= data_out`. If the size flit equals 0, go to END; otherwise go to PAYLOAD.
  - PAYLOAD: `data_av=!empty`. On each pop, `flit_cnt` decrements. A pop with `flit_cnt==1` goes to END.
  - END: `sender=0`, then go to IDLE (one cycle).
- `flit_cnt` is FLIT_W bits, unsigned, with no wrap. A size of 0 is legal and yields a 2-flit packet.
- `data_av=0` in IDLE, REQ and END.
- The FIFO keeps accepting link flits in every state, including flits of the next packet.

## Timing
- Reset (`reset==0` at a clock edge) forces:
  - `rd_ptr`, `wr_ptr`, `count` = 0
  - state = IDLE
  - `h`, `sender`, `flit_cnt` = 0
  - so `credit_o=1` and `data_av=0`
- Reset mid-packet discards all buffered flits. `sender` drops on the next edge, which the switch control sees as end of packet.
- Latencies:
  - First write into an empty buffer → `h=1` two cycles later (IDLE→REQ).
  - `ack_h` high at edge t → `sender=1` and `data_av` valid from t+1.
  - Pop of the last flit at edge t → state END at t+1 (`sender` still 1 during t..t+1), `sender=0` from t+2.
  - Earliest re-request for a queued next packet is `h=1` at t+3.
- `h`, `sender`, state and `flit_cnt` are registered. `data_av`, `credit_o` and `data_out` are combinational from state and occupancy.
- `ack_h` outside REQ is ignored. `data_ack` without `data_av` is ignored.

## Configuration
- `HERMES_IBUF_STATUS_EN`
  - Defined: adds output `occupancy [log2(DEPTH):0]` = `count`, registered, reset 0. Also adds output `pkt_err` (1 bit, sticky, cleared by reset only), set when `rx` is high while `credit_o` is 0.
  - Undefined: neither port exists. Overflow attempts are silently dropped, and FIFO/FSM behaviour is identical in both builds.

## Test plan
- Reset then header 0x2300, size 0x0002, payload 0xAAAA, 0xBBBB written back-to-back → `h=1` two cycles after the first write; `ack_h` pulse → four flits on `data_out` in order with `data_ack` held high; `sender` 1→0 two cycles after the last pop; state IDLE, count 0.
- Size 0 packet (0x1100, 0x0000) → exactly 2 pops, then END, `sender` falls.
- Fill DEPTH=16 without popping → `credit_o=0` at count 16. `rx` held high → no write, and with `HERMES_IBUF_STATUS_EN` `pkt_err=1`. One pop with `rx` high → next write accepted, count stays 16.
- Two packets queued back-to-back across pointer wrap (write 20 flits total with interleaved pops) → second `h` rises 3 cycles after the first packet's last pop, and the flit order is preserved across the wrap.
- `ack_h` held 0 for 50 cycles → `h` stays 1, `data_av` stays 0, no pops.
- Reset asserted mid-PAYLOAD → next cycle `sender=0`, `h=0`, count 0, `credit_o=1`.
